// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared constants for the SPI mode-0 target.
// Holds the FSM state encodings, synchroniser depth and parameter defaults.
package spi_target_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [15:0] DEFAULT_FILL    = 16'h00FF;
  localparam logic [3:0]  DEFAULT_MIN_GAP = 4'd8;

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT_IDLE = 2'd0;
  localparam state_t ST_IDLE      = 2'd1;
  localparam state_t ST_ACTIVE    = 2'd2;

endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: word-level handshake and status bundle between the SPI target
// and the core logic. The core side uses the master modport, the target the slave.
interface spi_target_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_start;
  logic             frame_end;
  logic             rx_abort;
  logic             tx_underrun;
  logic             busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, frame_start, frame_end,
           rx_abort, tx_underrun, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, frame_start, frame_end,
           rx_abort, tx_underrun, busy
  );

endinterface

// File: rtl/spi_input_sync.sv
// spi_input_sync: brings one asynchronous SPI pin into the clock domain and
// flags its edges. All flops clear to 0 so that a chip select held low across
// reset never looks like an idle bus until the real pin level has propagated.
module spi_input_sync
  import spi_target_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // Synchroniser chain plus one delayed copy of its output for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= '0;
      dly_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~dly_r;
  assign fall  = ~level & dly_r;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder oversampled in the system clock domain.
// Receives MOSI words, shifts a one-entry transmit holding register onto MISO
// (FILL when empty) and reports framing events to the core.
// Optional build macro SPI_TARGET_MIN_GAP_EN: reject frames whose CS_N-high
// gap before assertion is shorter than MIN_GAP clock cycles.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = DEFAULT_FILL[WIDTH-1:0]
`ifdef SPI_TARGET_MIN_GAP_EN
  ,
  parameter logic [3:0]       MIN_GAP = DEFAULT_MIN_GAP
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  spi_target_if.slave core
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  // synchronised pins
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_level_s, unused_mosi_rise_s, unused_mosi_fall_s;
  logic unused_sclk_level_s;

  // state
  state_t           state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             pending_r;
  logic [WIDTH-1:0] shift_in_r;
  logic [WIDTH-1:0] shift_out_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_empty_r;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;
  logic             frame_start_r;
  logic             frame_end_r;
  logic             rx_abort_r;
  logic             tx_underrun_r;
  logic             miso_oe_r;
  logic             busy_r;

  // decoded events
  logic start_s, reject_s, stop_s, bit_in_s, bit_out_s, wrap_s, load_s;
  logic gap_ok_s;

  spi_input_sync u_sync_sclk (
    .clock(clock), .reset(reset), .async_in(sclk),
    .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_input_sync u_sync_cs (
    .clock(clock), .reset(reset), .async_in(cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_input_sync u_sync_mosi (
    .clock(clock), .reset(reset), .async_in(mosi),
    .level(mosi_level_s), .rise(unused_mosi_rise_s), .fall(unused_mosi_fall_s)
  );

  assign unused_sclk_level_s = sclk_level_s;

`ifdef SPI_TARGET_MIN_GAP_EN
  logic [3:0] gap_cnt_r;

  // Count idle CS_N-high cycles; a short gap disqualifies the next assertion
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt_r <= MIN_GAP;
    end else if (stop_s || reject_s) begin
      gap_cnt_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && cs_level_s && (gap_cnt_r < MIN_GAP)) begin
      gap_cnt_r <= gap_cnt_r + 4'd1;
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

  // A frame is only accepted once the gap counter has saturated
  always_comb begin
    gap_ok_s = 1'b0;
    if (gap_cnt_r >= MIN_GAP) begin
      gap_ok_s = 1'b1;
    end else begin
      gap_ok_s = 1'b0;
    end
  end
`else
  assign gap_ok_s = 1'b1;
`endif

  // Decode frame and bit events; chip-select rising takes priority over SCLK
  always_comb begin
    start_s   = 1'b0;
    reject_s  = 1'b0;
    stop_s    = 1'b0;
    bit_in_s  = 1'b0;
    bit_out_s = 1'b0;
    if ((state_r == ST_IDLE) && cs_fall_s) begin
      start_s  = gap_ok_s;
      reject_s = ~gap_ok_s;
    end else if (state_r == ST_ACTIVE) begin
      stop_s    = cs_rise_s;
      bit_in_s  = ~cs_rise_s & sclk_rise_s;
      bit_out_s = ~cs_rise_s & sclk_fall_s;
    end else begin
      start_s = 1'b0;
    end
    wrap_s = bit_in_s && (bit_cnt_r == CNT_W'(WIDTH - 1));
    load_s = start_s || (bit_out_s && pending_r);
  end

  // Frame state machine and one-cycle framing pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_WAIT_IDLE;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      rx_abort_r    <= 1'b0;
      miso_oe_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_start_r <= start_s;
      frame_end_r   <= stop_s;
      rx_abort_r    <= stop_s && (bit_cnt_r != '0);
      case (state_r)
        ST_WAIT_IDLE: begin
          if (cs_level_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_ACTIVE;
            miso_oe_r <= 1'b1;
            busy_r    <= 1'b1;
          end else if (reject_s) begin
            state_r <= ST_WAIT_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (stop_s) begin
            state_r   <= ST_IDLE;
            miso_oe_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_WAIT_IDLE;
          miso_oe_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Bit counter and the "next word due on the coming falling edge" flag
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_r <= '0;
      pending_r <= 1'b0;
    end else if (start_s || stop_s) begin
      bit_cnt_r <= '0;
      pending_r <= 1'b0;
    end else if (wrap_s) begin
      bit_cnt_r <= '0;
      pending_r <= 1'b1;
    end else if (bit_in_s) begin
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end else if (bit_out_s) begin
      pending_r <= 1'b0;
    end
  end

  // Receive shifter; a completed word is published with a one-cycle strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_in_r <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= wrap_s;
      if (bit_in_s) begin
        shift_in_r <= {shift_in_r[WIDTH-2:0], mosi_level_s};
      end
      if (wrap_s) begin
        rx_data_r <= {shift_in_r[WIDTH-2:0], mosi_level_s};
      end
    end
  end

  // Transmit shifter and holding register; a load drains the holder or sends FILL
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_out_r   <= '0;
      hold_r        <= '0;
      hold_empty_r  <= 1'b1;
      tx_underrun_r <= 1'b0;
    end else begin
      tx_underrun_r <= load_s && hold_empty_r;
      if (load_s) begin
        shift_out_r <= hold_empty_r ? FILL : hold_r;
      end else if (bit_out_s) begin
        shift_out_r <= {shift_out_r[WIDTH-2:0], 1'b0};
      end
      if (load_s && !hold_empty_r) begin
        hold_empty_r <= 1'b1;
      end else if (core.tx_valid && hold_empty_r) begin
        hold_r       <= core.tx_data;
        hold_empty_r <= 1'b0;
      end
    end
  end

  assign miso             = shift_out_r[WIDTH-1];
  assign miso_oe          = miso_oe_r;
  assign core.tx_ready    = hold_empty_r;
  assign core.rx_data     = rx_data_r;
  assign core.rx_valid    = rx_valid_r;
  assign core.frame_start = frame_start_r;
  assign core.frame_end   = frame_end_r;
  assign core.rx_abort    = rx_abort_r;
  assign core.tx_underrun = tx_underrun_r;
  assign core.busy        = busy_r;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: self-checking bench for spi_target acting as SPI initiator.
// Expected RX and MISO words go into scoreboard queues when a word is driven
// and are compared when the DUT delivers rx_valid or the word finishes.
module tb_spi_target;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sclk  = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic miso;
  logic miso_oe;

  int vec_cnt = 0;
  int err_cnt = 0;

  int fs_cnt = 0, fe_cnt = 0, rv_cnt = 0, ur_cnt = 0, ab_cnt = 0;
  int fs_b, fe_b, rv_b, ur_b, ab_b;

  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];

  spi_target_if #(.WIDTH(W)) bus ();

  spi_target #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .core(bus)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // pulse counters and rx scoreboard, sampled on the falling clock edge
  always @(negedge clock) begin
    if (bus.frame_start) fs_cnt++;
    if (bus.frame_end)   fe_cnt++;
    if (bus.tx_underrun) ur_cnt++;
    if (bus.rx_abort)    ab_cnt++;
    if (bus.rx_valid) begin
      rv_cnt++;
      check_value("rx_pending", rx_q.size(), 1);
      if (rx_q.size() > 0) check_value("rx_data", bus.rx_data, rx_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    fs_b = fs_cnt; fe_b = fe_cnt; rv_b = rv_cnt; ur_b = ur_cnt; ab_b = ab_cnt;
  endtask

  task automatic check_counts(input string t, input int fs, input int fe, input int rv,
                              input int ur, input int ab);
    check_value({t, ".frame_start"}, fs_cnt - fs_b, fs);
    check_value({t, ".frame_end"},   fe_cnt - fe_b, fe);
    check_value({t, ".rx_valid"},    rv_cnt - rv_b, rv);
    check_value({t, ".tx_underrun"}, ur_cnt - ur_b, ur);
    check_value({t, ".rx_abort"},    ab_cnt - ab_b, ab);
  endtask

  task automatic write_tx(input logic [7:0] d);
    int budget;
    budget = 0;
    while (!bus.tx_ready && budget < 100) begin
      tick(1);
      budget++;
    end
    check_value("tx_ready_wait", bus.tx_ready, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  // n mode-0 bits; with end_frame the last SCLK fall coincides with CS_N rising
  task automatic run_bits(input int n, input logic [7:0] mo, input bit end_frame,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = mo[7-i];
      tick(4);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      if (end_frame && (i == n - 1)) cs_n = 1'b1;
    end
  endtask

  task automatic xfer_word(input logic [7:0] mo, input logic [7:0] exp_mi, input bit last);
    logic [7:0] mi;
    rx_q.push_back(mo);
    miso_q.push_back(exp_mi);
    run_bits(8, mo, last, mi);
    check_value("miso_word", mi, miso_q.pop_front());
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    tick(4);
  endtask

  initial begin
    logic [7:0] mi;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // reset values
    tick(4);
    check_value("rst.miso", miso, 0);
    check_value("rst.miso_oe", miso_oe, 0);
    check_value("rst.tx_ready", bus.tx_ready, 1);
    check_value("rst.rx_data", bus.rx_data, 0);
    check_value("rst.pulses", {bus.rx_valid, bus.frame_start, bus.frame_end,
                               bus.rx_abort, bus.tx_underrun}, 0);
    check_value("rst.busy", bus.busy, 0);
    reset = 1'b0;
    tick(12);

    // 1: preloaded A5, one word
    snap();
    write_tx(8'hA5);
    cs_begin();
    check_value("t1.miso_oe", miso_oe, 1);
    check_value("t1.busy", bus.busy, 1);
    xfer_word(8'h3C, 8'hA5, 1'b1);
    tick(12);
    check_value("t1.miso_oe_end", miso_oe, 0);
    check_counts("t1", 1, 1, 1, 0, 0);

    // 2: two words, second written during the first
    snap();
    write_tx(8'h12);
    cs_begin();
    fork
      xfer_word(8'hC3, 8'h12, 1'b0);
      begin tick(12); write_tx(8'h34); end
    join
    xfer_word(8'h96, 8'h34, 1'b1);
    tick(12);
    check_counts("t2", 1, 1, 2, 0, 0);

    // 3: empty holding register sends FILL
    snap();
    cs_begin();
    xfer_word(8'h5A, 8'hFF, 1'b1);
    tick(12);
    check_counts("t3", 1, 1, 1, 1, 0);

    // 4: partial word aborts, next frame is clean
    snap();
    cs_begin();
    run_bits(5, 8'hE7, 1'b1, mi);
    tick(12);
    check_counts("t4a", 1, 1, 0, 1, 1);
    snap();
    write_tx(8'h69);
    cs_begin();
    xfer_word(8'h81, 8'h69, 1'b1);
    tick(12);
    check_counts("t4b", 1, 1, 1, 0, 0);

    // 5: reset mid-word with CS_N held low
    write_tx(8'hC0);
    cs_begin();
    run_bits(3, 8'hFF, 1'b0, mi);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_value("t5.miso_oe", miso_oe, 0);
    check_value("t5.busy", bus.busy, 0);
    check_value("t5.tx_ready", bus.tx_ready, 1);
    check_value("t5.rx_data", bus.rx_data, 0);
    snap();
    run_bits(8, 8'hAA, 1'b0, mi);
    check_value("t5.miso_oe_ign", miso_oe, 0);
    check_counts("t5a", 0, 0, 0, 0, 0);
    cs_n = 1'b1;
    tick(12);
    snap();
    write_tx(8'h3E);
    cs_begin();
    xfer_word(8'h7E, 8'h3E, 1'b1);
    tick(12);
    check_counts("t5b", 1, 1, 1, 0, 0);

    // 6: CS_N re-asserted shortly after a frame
    cs_begin();
    xfer_word(8'h24, 8'hFF, 1'b1);
    write_tx(8'h4B);
    tick(4);
    snap();
`ifdef SPI_TARGET_MIN_GAP_EN
    cs_n = 1'b0;
    tick(4);
    run_bits(8, 8'h55, 1'b0, mi);
    check_value("t6.miso_oe_rej", miso_oe, 0);
    check_counts("t6a", 0, 0, 0, 0, 0);
    cs_n = 1'b1;
    tick(10);
    snap();
    cs_begin();
    check_value("t6.miso_oe_acc", miso_oe, 1);
    xfer_word(8'hD2, 8'h4B, 1'b1);
    tick(12);
    check_counts("t6b", 1, 1, 1, 0, 0);
`else
    cs_begin();
    check_value("t6.miso_oe_acc", miso_oe, 1);
    xfer_word(8'hD2, 8'h4B, 1'b1);
    tick(12);
    check_counts("t6", 1, 1, 1, 0, 0);
`endif

    check_value("rx_q_left", rx_q.size(), 0);
    check_value("miso_q_left", miso_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
